// File: rtl/router_rd_arb_pkg.sv
// Shared types and constants for the router read-side arbiter.
//   state_t      : scheduler FSM states
//   skid_entry_t : one buffered downstream beat {data, sop, eop, port}
//                  (plus err when ROUTER_RD_ARB_PARITY_CHECK_EN is defined)
//   rr_pick      : round-robin winner among three requesters
package router_rd_arb_pkg;

  localparam int RD_DATA_WIDTH = 8;
  localparam int RD_LEN_WIDTH  = 6;
  localparam int RD_PORT_W     = 2;
  localparam int RD_CNT_W      = RD_LEN_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_HDR  = 2'd1,
    RD_BODY = 2'd2
  } state_t;

  typedef struct packed {
    logic [RD_DATA_WIDTH-1:0] data;
    logic                     sop;
    logic                     eop;
    logic [RD_PORT_W-1:0]     port;
`ifdef ROUTER_RD_ARB_PARITY_CHECK_EN
    logic                     err;
`endif
  } skid_entry_t;

  // First requester found scanning (ptr+1)%3, (ptr+2)%3, ptr. The loop runs
  // from the lowest priority upward so the highest-priority hit is written last.
  function automatic logic [RD_PORT_W-1:0] rr_pick(input logic [RD_PORT_W-1:0] ptr,
                                                   input logic [2:0]           req);
    logic [RD_PORT_W-1:0] pick;
    int idx;
    pick = ptr;
    for (int k = 3; k >= 1; k--) begin
      idx = (int'(ptr) + k) % 3;
      if (req[idx]) pick = RD_PORT_W'(idx);
    end
    return pick;
  endfunction

endpackage

// File: rtl/router_rd_arb_skid.sv
// Two-entry skid buffer between the FIFO capture stage and the downstream link.
// Ports:
//   clock, reset       : clock, asynchronous active-high reset
//   push, push_entry   : write one beat (capture cycle)
//   pop                : remove the head beat (downstream transfer)
//   head               : oldest beat, drives the downstream outputs
//   occupancy          : number of stored beats (0..2)
// Push and pop may occur in the same cycle. Storage is not reset; only the
// pointers and occupancy are, so head is meaningful only when occupancy != 0.
module router_rd_arb_skid
  import router_rd_arb_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  skid_entry_t push_entry,
  input  logic        pop,
  output skid_entry_t head,
  output logic [1:0]  occupancy
);

  skid_entry_t mem [2];
  logic        wr_ptr;
  logic        rd_ptr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      occupancy <= occupancy + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/router_rd_arbiter.sv
// Read-side scheduler for the 1x3 router. Drains the three output FIFOs onto
// one downstream byte link a whole packet at a time, round-robin among ports
// whose not-empty flag is high. The header byte sizes the burst
// (len = header[7:2], followed by len payload bytes and one parity byte).
// Ports:
//   clock, reset          : clock, asynchronous active-high reset
//   vld_out_0..2          : FIFO not-empty flags
//   data_out_0..2         : FIFO read data, valid the cycle after read_enb_x
//   read_enb_0..2         : FIFO read strobes, at most one high per cycle
//   m_data/m_valid/m_ready: downstream byte handshake
//   m_sop, m_eop          : header / parity byte markers
//   m_port                : source FIFO of the current byte
//   grant                 : one-hot port currently owned, 0 when idle
//   arb_busy              : FSM not in IDLE
//   parity_err            : only with ROUTER_RD_ARB_PARITY_CHECK_EN; pulses with
//                           the eop transfer when the parity byte mismatches the
//                           XOR of header and payload
module router_rd_arbiter
  import router_rd_arb_pkg::*;
#(
  parameter int DATA_WIDTH = RD_DATA_WIDTH,
  parameter int LEN_WIDTH  = RD_LEN_WIDTH,
  parameter int PORTS      = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  vld_out_0,
  input  logic                  vld_out_1,
  input  logic                  vld_out_2,
  input  logic [DATA_WIDTH-1:0] data_out_0,
  input  logic [DATA_WIDTH-1:0] data_out_1,
  input  logic [DATA_WIDTH-1:0] data_out_2,
  output logic                  read_enb_0,
  output logic                  read_enb_1,
  output logic                  read_enb_2,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_sop,
  output logic                  m_eop,
  output logic [RD_PORT_W-1:0]  m_port,
  output logic [PORTS-1:0]      grant,
  output logic                  arb_busy
`ifdef ROUTER_RD_ARB_PARITY_CHECK_EN
  ,
  output logic                  parity_err
`endif
);

  localparam int CNT_W = LEN_WIDTH + 1;

  state_t                 state, state_nxt;
  logic [RD_PORT_W-1:0]   rr_ptr, rr_nxt;
  logic [RD_PORT_W-1:0]   gidx, gidx_nxt;
  logic [RD_PORT_W-1:0]   pick;
  logic [PORTS-1:0]       grant_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt, remaining;
  logic [PORTS-1:0]       req;
  logic                   vld_g;
  logic                   room;
  logic [2:0]             load;
  logic                   issue, issue_sop, issue_eop;

  logic                   cap_vld_p1, cap_sop_p1, cap_eop_p1;
  logic [RD_PORT_W-1:0]   cap_port_p1;
  logic [DATA_WIDTH-1:0]  cap_data;
  logic [LEN_WIDTH-1:0]   hdr_len;

  skid_entry_t            push_entry;
  skid_entry_t            head;
  logic [1:0]             occupancy;
  logic                   pop;

  assign req   = {vld_out_2, vld_out_1, vld_out_0};
  assign vld_g = req[gidx];
  assign pick  = rr_pick(rr_ptr, req);

  assign pop     = m_valid && m_ready;
  assign m_valid = (occupancy != 2'd0);

  // Beats buffered after this cycle's pop plus the read already in flight.
  // Counting the pop lets a new read issue every cycle while m_ready stays high.
  assign load = 3'(occupancy) + 3'(cap_vld_p1) - 3'(pop);
  assign room = (load < 3'd2);

  // The header arrives in the first RD_BODY cycle; its length is used in that
  // same cycle so body reads start without a bubble.
  assign hdr_len   = cap_data[DATA_WIDTH-1 -: LEN_WIDTH];
  assign remaining = (cap_vld_p1 && cap_sop_p1) ? CNT_W'(hdr_len) + CNT_W'(1) : cnt;

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    gidx_nxt  = gidx;
    grant_nxt = grant;
    cnt_nxt   = remaining;
    issue     = 1'b0;
    issue_sop = 1'b0;
    issue_eop = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          rr_nxt    = pick;
          gidx_nxt  = pick;
          grant_nxt = PORTS'(1) << pick;
          state_nxt = RD_HDR;
        end
      end
      RD_HDR: begin
        if (vld_g && room) begin
          issue     = 1'b1;
          issue_sop = 1'b1;
          state_nxt = RD_BODY;
        end
      end
      RD_BODY: begin
        if (vld_g && room && (remaining != '0)) begin
          issue   = 1'b1;
          cnt_nxt = remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            issue_eop = 1'b1;
            state_nxt = IDLE;
            grant_nxt = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign read_enb_0 = issue && (gidx == 2'd0);
  assign read_enb_1 = issue && (gidx == 2'd1);
  assign read_enb_2 = issue && (gidx == 2'd2);
  assign arb_busy   = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= 2'd2;
      gidx        <= 2'd0;
      grant       <= '0;
      cnt         <= '0;
      cap_vld_p1  <= 1'b0;
      cap_sop_p1  <= 1'b0;
      cap_eop_p1  <= 1'b0;
      cap_port_p1 <= 2'd0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_nxt;
      gidx        <= gidx_nxt;
      grant       <= grant_nxt;
      cnt         <= cnt_nxt;
      cap_vld_p1  <= issue;
      cap_sop_p1  <= issue_sop;
      cap_eop_p1  <= issue_eop;
      cap_port_p1 <= gidx;
    end
  end

  // Capture stage (_p1): FIFO data returns one cycle after its read strobe.
  always_comb begin
    case (cap_port_p1)
      2'd1:    cap_data = data_out_1;
      2'd2:    cap_data = data_out_2;
      default: cap_data = data_out_0;
    endcase
  end

`ifdef ROUTER_RD_ARB_PARITY_CHECK_EN
  logic [DATA_WIDTH-1:0] par_acc_p1;

  always_ff @(posedge clock) begin
    if (cap_vld_p1) begin
      if (cap_sop_p1)       par_acc_p1 <= cap_data;
      else if (!cap_eop_p1) par_acc_p1 <= par_acc_p1 ^ cap_data;
    end
  end
`endif

  always_comb begin
    push_entry      = '0;
    push_entry.data = cap_data;
    push_entry.sop  = cap_sop_p1;
    push_entry.eop  = cap_eop_p1;
    push_entry.port = cap_port_p1;
`ifdef ROUTER_RD_ARB_PARITY_CHECK_EN
    push_entry.err  = cap_eop_p1 && (par_acc_p1 != cap_data);
`endif
  end

  router_rd_arb_skid u_skid (
    .clock      (clock),
    .reset      (reset),
    .push       (cap_vld_p1),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .occupancy  (occupancy)
  );

  // Skid storage is not reset, so outputs are qualified by m_valid.
  assign m_data = m_valid ? head.data : '0;
  assign m_sop  = m_valid && head.sop;
  assign m_eop  = m_valid && head.eop;
  assign m_port = m_valid ? head.port : '0;

`ifdef ROUTER_RD_ARB_PARITY_CHECK_EN
  assign parity_err = pop && head.eop && head.err;
`endif

endmodule

// File: tb/tb_router_rd_arbiter.sv
module tb_router_rd_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic [7:0] data_out_0, data_out_1, data_out_2;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_sop, m_eop;
  logic [1:0] m_port;
  logic [2:0] grant;
  logic       arb_busy;
`ifdef ROUTER_RD_ARB_PARITY_CHECK_EN
  logic       parity_err;
`endif

  always #5 clock = ~clock;

  router_rd_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .vld_out_0  (vld_out_0),
    .vld_out_1  (vld_out_1),
    .vld_out_2  (vld_out_2),
    .data_out_0 (data_out_0),
    .data_out_1 (data_out_1),
    .data_out_2 (data_out_2),
    .read_enb_0 (read_enb_0),
    .read_enb_1 (read_enb_1),
    .read_enb_2 (read_enb_2),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_sop      (m_sop),
    .m_eop      (m_eop),
    .m_port     (m_port),
    .grant      (grant),
    .arb_busy   (arb_busy)
`ifdef ROUTER_RD_ARB_PARITY_CHECK_EN
    ,
    .parity_err (parity_err)
`endif
  );

  typedef struct {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic [1:0] port;
    logic       perr;
  } exp_t;

  exp_t exp_q[$];
  exp_t pend_q[$];

  int checks   = 0;
  int failures = 0;

  // Router FIFO model: one byte array per port with free-running pointers.
  logic [7:0] mem [3][4096];
  int         wptr [3] = '{0, 0, 0};
  int         rptr [3] = '{0, 0, 0};
  int         rd_cnt [3] = '{0, 0, 0};
  int         rd_total = 0;
  int         empty_rd = 0;
  int         multi_rd = 0;
  logic [7:0] dout [3];
  logic [2:0] hold_man = 3'b000;
  logic [2:0] hold_rnd = 3'b000;
  int         rdy_mode = 0;
  int         gap_en   = 0;
  int         model_ptr = 2;
  int         xfer_total = 0;
  int         max_out = 0;

  logic [2:0]  re;
  logic [19:0] outs_all;

  assign re = {read_enb_2, read_enb_1, read_enb_0};
  assign outs_all = {read_enb_2, read_enb_1, read_enb_0, m_valid, m_sop, m_eop,
                     m_port, grant, arb_busy, m_data};
  assign vld_out_0 = (wptr[0] != rptr[0]) && !hold_man[0] && !hold_rnd[0];
  assign vld_out_1 = (wptr[1] != rptr[1]) && !hold_man[1] && !hold_rnd[1];
  assign vld_out_2 = (wptr[2] != rptr[2]) && !hold_man[2] && !hold_rnd[2];
  assign data_out_0 = dout[0];
  assign data_out_1 = dout[1];
  assign data_out_2 = dout[2];

  always @(posedge clock) begin
    if (reset) begin
      rd_total <= 0;
    end else begin
      if ($countones(re) > 1) multi_rd <= multi_rd + 1;
      for (int p = 0; p < 3; p++) begin
        if (re[p]) begin
          if (wptr[p] == rptr[p]) empty_rd <= empty_rd + 1;
          dout[p]   <= mem[p][rptr[p] % 4096];
          rptr[p]   <= rptr[p] + 1;
          rd_cnt[p] <= rd_cnt[p] + 1;
        end
      end
      if (|re) rd_total <= rd_total + 1;
    end
  end

  // Downstream ready and random FIFO underrun on the granted port.
  always @(posedge clock) begin
    #1;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      default: m_ready = (($urandom % 3) != 0);
    endcase
    for (int p = 0; p < 3; p++)
      hold_rnd[p] = (gap_en != 0) && grant[p] && (($urandom % 4) == 0);
  end

  // Monitor: pops the scoreboard on every downstream transfer.
  logic       stall_prev = 1'b0;
  logic [7:0] sv_data;
  logic       sv_sop, sv_eop;
  logic [1:0] sv_port;

  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      xfer_total = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (!(m_valid && m_data == sv_data && m_sop == sv_sop && m_eop == sv_eop && m_port == sv_port)) begin
          failures++;
          $display("FAIL hold_stable got v=%0b d=%h sop=%0b eop=%0b port=%0d exp d=%h sop=%0b eop=%0b port=%0d",
                   m_valid, m_data, m_sop, m_eop, m_port, sv_data, sv_sop, sv_eop, sv_port);
        end
      end
      stall_prev = m_valid && !m_ready;
      sv_data = m_data; sv_sop = m_sop; sv_eop = m_eop; sv_port = m_port;
      if (m_valid && m_ready) begin
        if (rd_total - xfer_total > max_out) max_out = rd_total - xfer_total;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_byte got d=%h sop=%0b eop=%0b port=%0d exp none",
                   m_data, m_sop, m_eop, m_port);
        end else begin
          e = exp_q.pop_front();
          if (m_data != e.data || m_sop != e.sop || m_eop != e.eop || m_port != e.port) begin
            failures++;
            $display("FAIL beat got d=%h sop=%0b eop=%0b port=%0d exp d=%h sop=%0b eop=%0b port=%0d",
                     m_data, m_sop, m_eop, m_port, e.data, e.sop, e.eop, e.port);
          end
`ifdef ROUTER_RD_ARB_PARITY_CHECK_EN
          checks++;
          if (parity_err != e.perr) begin
            failures++;
            $display("FAIL parity_err got %0b exp %0b", parity_err, e.perr);
          end
`endif
        end
        xfer_total++;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_byte(input int p, input logic [7:0] b, input logic sop,
                           input logic eop, input logic perr);
    exp_t e;
    mem[p][wptr[p] % 4096] = b;
    wptr[p] = wptr[p] + 1;
    e.data = b; e.sop = sop; e.eop = eop; e.port = 2'(p); e.perr = perr;
    pend_q.push_back(e);
  endtask

  // Packet = header, header[7:2] random payload bytes, XOR parity byte.
  task automatic load_pkt(input int p, input logic [7:0] hdr, input bit corrupt);
    logic [7:0] par, b;
    int len;
    len = int'(hdr[7:2]);
    par = hdr;
    push_byte(p, hdr, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      par = par ^ b;
      push_byte(p, b, 1'b0, 1'b0, 1'b0);
    end
    if (corrupt) par = par ^ 8'h01;
    push_byte(p, par, 1'b0, 1'b1, corrupt);
  endtask

  function automatic bit has_pend(input int p);
    foreach (pend_q[i]) if (pend_q[i].port == 2'(p)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic commit_port(input int p);
    exp_t e;
    int idx;
    idx = -1;
    foreach (pend_q[i]) if (idx < 0 && pend_q[i].port == 2'(p)) idx = i;
    if (idx >= 0) begin
      do begin
        e = pend_q[idx];
        pend_q.delete(idx);
        exp_q.push_back(e);
      end while (!e.eop && idx < pend_q.size());
    end
    model_ptr = p;
  endtask

  // Whole-packet round robin over ports with pending packets.
  task automatic rr_commit_all();
    int p;
    bit found;
    while (pend_q.size() > 0) begin
      found = 1'b0;
      for (int k = 1; k <= 3; k++) begin
        p = (model_ptr + k) % 3;
        if (!found && has_pend(p)) begin
          found = 1'b1;
          commit_port(p);
        end
      end
      if (!found) pend_q.delete();
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && !arb_busy && !m_valid) done = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_drain got %0d bytes outstanding exp 0 within %0d cycles", name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic check_val(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      failures++;
      $display("FAIL %s got %0d exp %0d", name, got, expv);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n, len;
    bit seen;
    reset   = 1'b1;
    m_ready = 1'b1;
    #12;
    check_val("reset_outputs", int'(outs_all), 0);
    tick();
    reset = 1'b0;

    // Port 2, len 5.
    base = rd_cnt[2];
    load_pkt(2, 8'h16, 1'b0);
    rr_commit_all();
    wait_drain("p2_len5", 500);
    check_val("p2_read_count", rd_cnt[2] - base, 7);
    check_val("p2_grant_idle", int'(grant), 0);

    // Fresh reset, all three ports pending, then port 0 refilled mid port 2.
    tick(); reset = 1'b1; tick(); tick(); reset = 1'b0;
    model_ptr = 2;
    for (int p = 0; p < 3; p++) load_pkt(p, {6'($urandom_range(0, 6)), 2'(p)}, 1'b0);
    rr_commit_all();
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clock);
      if (grant == 3'b100) seen = 1'b1;
    end
    check_val("grant_reaches_p2", int'(seen), 1);
    tick();
    load_pkt(0, 8'h0C, 1'b0);
    rr_commit_all();
    wait_drain("rr_order", 1000);

    // Port 1, len 14, m_ready toggling.
    rdy_mode = 1;
    load_pkt(1, 8'h39, 1'b0);
    rr_commit_all();
    wait_drain("p1_toggle", 1000);
    rdy_mode = 0;

    // Port 0, len 0, then a packet with a corrupted parity byte.
    load_pkt(0, 8'h00, 1'b0);
    rr_commit_all();
    wait_drain("p0_len0", 300);
    load_pkt(0, 8'h0C, 1'b1);
    rr_commit_all();
    wait_drain("p0_badpar", 300);

    // Port 0 underrun for 5 cycles after the third payload byte is read.
    base = rd_cnt[0];
    load_pkt(0, 8'h18, 1'b0);
    rr_commit_all();
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (rd_cnt[0] - base >= 4) seen = 1'b1;
    end
    hold_man[0] = 1'b1;
    check_val("gap_reached", int'(seen), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check_val("gap_no_read_grant_held", int'({read_enb_0, grant}), 1);
      @(posedge clock);
      #1;
    end
    hold_man[0] = 1'b0;
    wait_drain("gap", 300);

    // Randomized rounds with random ready and random underruns.
    gap_en = 1;
    rdy_mode = 2;
    for (int r = 0; r < 6; r++) begin
      for (int p = 0; p < 3; p++) begin
        n = $urandom_range(0, 2);
        for (int j = 0; j < n; j++) begin
          len = $urandom_range(0, 20);
          load_pkt(p, {6'(len), 2'($urandom)}, (($urandom % 5) == 0));
        end
      end
      rr_commit_all();
      wait_drain("random", 3000);
    end
    gap_en = 0;
    rdy_mode = 0;
    tick();

    // Reset asserted mid-packet.
    load_pkt(2, {6'd12, 2'd2}, 1'b0);
    rr_commit_all();
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clock);
      if (xfer_total >= 3) seen = 1'b1;
    end
    check_val("midpkt_progress", int'(seen), 1);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_val("async_reset_outputs", int'(outs_all), 0);
    tick();
    tick();
    exp_q.delete();
    pend_q.delete();
    for (int p = 0; p < 3; p++) wptr[p] = rptr[p];
    model_ptr = 2;
    reset = 1'b0;
    load_pkt(1, 8'h09, 1'b0);
    load_pkt(0, 8'h10, 1'b0);
    rr_commit_all();
    wait_drain("after_reset", 500);

    check_val("multi_read_cycles", multi_rd, 0);
    check_val("reads_from_empty", empty_rd, 0);
    check_val("max_outstanding_le2", int'(max_out <= 2), 1);
    check_val("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/router_rd_arbiter.md
Name: router_rd_arbiter

Overview:
- Read-side scheduler for the 1x3 router: drains the three output FIFOs onto one shared downstream byte link, one whole packet at a time.
- Grants FIFOs round-robin among ports whose valid flag is high.
- Decodes each packet's header byte to size the burst, and drives the router's read_enb_0..2.

Parameters:
- DATA_WIDTH, 8, byte width of FIFO and downstream data.
- LEN_WIDTH, 6, payload length field width (header[7:2]).
- PORTS, 3, number of router output FIFOs (fixed at 3; other values unsupported).

Ports:
- clock  input  1  single clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- vld_out_0/1/2  input  1  router FIFO not-empty flags.
- data_out_0/1/2  input  8  router FIFO read data; valid the cycle after the matching read_enb pulse.
- read_enb_0/1/2  output  1  FIFO read strobes; at most one high per cycle.
- m_data  output  8  downstream byte.
- m_valid  output  1  m_data valid.
- m_ready  input  1  downstream accept; a byte transfers when m_valid && m_ready.
- m_sop  output  1  high with the header byte.
- m_eop  output  1  high with the parity byte.
- m_port  output  2  source FIFO index of the current byte.
- grant  output  3  one-hot port currently owned; 0 when idle.
- arb_busy  output  1  high when the FSM is not in IDLE.

Behaviour:
- Reset (async, active-high): FSM=IDLE, rr_ptr=2 (so port 0 wins first), byte counter=0, skid buffer empty. All outputs are 0: read_enb_*, m_valid, m_sop, m_eop, m_port, grant, arb_busy, m_data.
- Reset asserted mid-packet: the in-flight packet is abandoned with no m_eop. The router FIFO is not flushed by this block.
- FSM states: IDLE, RD_HDR, RD_BODY.
- IDLE: if any vld_out_x=1, grant the first requester scanning (rr_ptr+1)%3, (rr_ptr+2)%3, rr_ptr.
  - Update rr_ptr to the granted port, set grant, go to RD_HDR the next cycle.
  - Example: rr_ptr=0 with requests {0,2} -> grant 2.
- Read issue rule, in RD_HDR and RD_BODY: assert read_enb_g in cycle N only if all hold:
  - vld_out_g=1,
  - skid_occupancy + reads_in_flight < 2,
  - bytes remaining > 0.
  - Captured data lands in the skid buffer in cycle N+1.
- RD_HDR: the first captured byte is the header.
  - Latch len=header[7:2]; remaining body bytes = len+1 (payload plus parity).
  - Tag the byte sop=1. Go to RD_BODY once the header read is issued.
- RD_BODY: issue body reads per the rule, decrementing the counter per issued read.
  - The last issued read (the parity byte) is tagged eop=1.
  - After the last read is issued, return to IDLE. Arbitration for the next packet may overlap the drain of the skid buffer.
- len=0: packet is header + parity; the parity byte carries eop.
- vld_out_g dropping mid-packet (FIFO underrun while the router is still writing): stall issuing; grant is held, no timeout.
- Skid buffer: 2 entries of {data, sop, eop, port}.
  - Head drives m_*; pop on m_valid && m_ready; push on the capture cycle.
  - Simultaneous push and pop is allowed.
  - Sustains 1 byte/cycle with m_ready held high.
  - m_data, m_sop, m_eop and m_port are stable while m_valid && !m_ready.
- Header field header[1:0] is not checked against the granted port.

Optional Feature:
- Macro: ROUTER_RD_ARB_PARITY_CHECK_EN.
- With the macro defined:
  - Running XOR over header and payload bytes of the packet.
  - Compared with the parity byte at capture.
  - Adds output parity_err (1 bit), pulsed high for one cycle together with the eop byte transfer on mismatch; reset value 0.
- Without the macro: the parity_err port and logic are absent.

Decomposition:
- Package router_rd_arb_pkg:
  - state enum {IDLE, RD_HDR, RD_BODY},
  - DATA_WIDTH/LEN_WIDTH constants,
  - skid entry struct {data, sop, eop, port},
  - port index width constant (2).
- Sub-module router_rd_arb_skid: the 2-entry buffer with push/pop/occupancy.
- Top holds the FSM, round-robin pointer, counter and read-issue logic.

Test Plan:
- Port 2 holds header 0x16 (len 5), 5 payload bytes, parity; m_ready=1 -> 7 bytes on m_data with m_port=2, sop on byte 0, eop on byte 6; read_enb_2 high 7 cycles total; grant returns to 0.
- Ports 0,1,2 all valid after reset -> packets emitted in order 0,1,2; port 0 refilled during port 2's packet -> port 0 granted next.
- Port 1, len 14, m_ready toggling 1/0 every cycle -> all 16 bytes in order, none lost or duplicated; never more than 2 reads outstanding plus buffered.
- Port 0, header 0x00 (len 0) -> exactly 2 bytes, eop on the second byte.
- vld_out_0 dropped for 5 cycles after the 3rd payload byte -> no read_enb_0 during the gap, grant held, packet completes intact after vld returns.
- Reset pulsed mid-packet -> all outputs 0 asynchronously; after release the next request is arbitrated from port 0 priority. With ROUTER_RD_ARB_PARITY_CHECK_EN, a corrupted parity byte yields a parity_err pulse on the eop beat.
